// File: rtl/spi_regbank_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_regbank_if
// Description : SPI mode-0 pin bundle between the controller and the
//               spi_regbank peripheral.
// Revision    : 1.0
// ============================================================================
interface spi_regbank_if;
    logic nCS;
    logic SCLK;
    logic COPI;
    logic CIPO;
    logic CIPO_oe;

    modport master (
        output nCS,
        output SCLK,
        output COPI,
        input  CIPO,
        input  CIPO_oe
    );

    modport slave (
        input  nCS,
        input  SCLK,
        input  COPI,
        output CIPO,
        output CIPO_oe
    );
endinterface
`default_nettype wire

// File: rtl/spi_regbank.sv
`default_nettype none
// ============================================================================
// Module      : spi_regbank
// Description : SPI mode-0 peripheral register bank with read-back on CIPO,
//               per-register write strobes and framing-error pulses.
// Revision    : 1.0
// ============================================================================
module spi_regbank #(
    parameter int                 NUM_REGS    = 5,
    parameter int                 DATA_W      = 8,
    parameter int                 ADDR_W      = 7,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    spi_regbank_if.slave                      spi,
    output logic [NUM_REGS*DATA_W-1:0]        regs_flat,
    output logic [NUM_REGS-1:0]               wr_strobe,
    output logic                              frame_err
);

    localparam int c_FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int c_CNT_MAX   = c_FRAME_LEN + 1;
    localparam int c_CNT_W     = $clog2(c_FRAME_LEN + 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic                   r_ncs_prev;
    logic                   r_sclk_prev;

    state_t                 r_state;
    state_t                 w_next;
    logic [c_CNT_W-1:0]     r_count;
    logic [ADDR_W:0]        r_cmd;
    logic [DATA_W-1:0]      r_data;
    logic [DATA_W-1:0]      r_tx;
    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wr_strobe;
    logic                   r_frame_err;

    logic                   w_ncs;
    logic                   w_sclk;
    logic                   w_copi;
    logic                   w_ncs_rise;
    logic                   w_ncs_fall;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_sclk_active;
    logic [ADDR_W:0]        w_cmd_shift;
    logic [DATA_W-1:0]      w_data_shift;
    logic [DATA_W-1:0]      w_rd_val;
    logic                   w_to_rd;
    logic                   w_commit;
    logic                   w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ncs_sync  <= '1;
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_prev  <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0],  spi.nCS};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.COPI};
            r_ncs_prev  <= w_ncs;
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_ncs        = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi       = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_rise   = w_ncs & ~r_ncs_prev;
    assign w_ncs_fall   = ~w_ncs & r_ncs_prev;
    assign w_sclk_rise  = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall  = ~w_sclk & r_sclk_prev;
    // nCS edges take priority over any SCLK edge seen in the same cycle
    assign w_sclk_active = (r_state != S_IDLE) && !w_ncs_rise && !w_ncs_fall;
    assign w_cmd_shift  = {r_cmd[ADDR_W-1:0], w_copi};
    assign w_data_shift = {r_data[DATA_W-2:0], w_copi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_ncs_rise) begin
            w_next = S_IDLE;
        end else if (w_ncs_fall) begin
            w_next = S_CMD;
        end else if (w_sclk_rise) begin
            case (r_state)
                S_CMD: begin
                    if (r_count == c_CNT_W'(ADDR_W)) begin
                        w_next = w_cmd_shift[ADDR_W] ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    if (r_count == c_CNT_W'(c_FRAME_LEN - 1)) begin
                        w_next = S_DONE;
                    end
                end
                default: w_next = r_state;
            endcase
        end
    end

    assign w_to_rd = (r_state == S_CMD) && (w_next == S_RD);

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_shift[ADDR_W-1:0] == ADDR_W'(i)) begin
                w_rd_val = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_cmd   <= '0;
            r_data  <= '0;
            r_tx    <= '0;
        end else if (w_ncs_rise || w_ncs_fall) begin
            r_count <= '0;
            r_cmd   <= '0;
            r_data  <= '0;
            r_tx    <= '0;
        end else if (w_sclk_active) begin
            if (w_sclk_rise) begin
                if (r_count != c_CNT_W'(c_CNT_MAX)) begin
                    r_count <= r_count + 1'b1;
                end
                if (r_state == S_CMD) begin
                    r_cmd <= w_cmd_shift;
                end
                if (r_state == S_WR) begin
                    r_data <= w_data_shift;
                end
            end
            // The fall right after the last address bit must keep the MSB
            // on CIPO for the first data rise, so no shift until then.
            if (w_to_rd) begin
                r_tx <= w_rd_val;
            end else if ((r_state == S_RD) && w_sclk_fall &&
                         (r_count > c_CNT_W'(ADDR_W + 1))) begin
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign w_commit = w_ncs_rise && (r_count == c_CNT_W'(c_FRAME_LEN)) && r_cmd[ADDR_W];
    assign w_err    = w_ncs_rise && (r_count != '0) && (r_count != c_CNT_W'(c_FRAME_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_wr_strobe[i] <= w_commit && (r_cmd[ADDR_W-1:0] == ADDR_W'(i));
                if (w_commit && (r_cmd[ADDR_W-1:0] == ADDR_W'(i))) begin
                    r_regs[i] <= r_data;
                end
            end
            r_frame_err <= w_err;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign wr_strobe   = r_wr_strobe;
    assign frame_err   = r_frame_err;
    assign spi.CIPO_oe = (r_state == S_RD);
    assign spi.CIPO    = (r_state == S_RD) & r_tx[DATA_W-1];

endmodule
`default_nettype wire
